// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front end: trigger generation, echo timing and truncating cm conversion.
// Optional ULTRASONIC_MEDIAN3_EN: dist_cm becomes the median of the last three samples.
module ultrasonic_ranger #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TRIG_US     = 10,
  parameter int PERIOD_MS   = 60,
  parameter int TIMEOUT_US  = 25000,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 400,
  parameter int DIST_W      = 9
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic [2:0]        o_dbg_state
);

  localparam int DIV       = CLK_FREQ_HZ / 1000000;
  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int US_MAX    = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PER_W     = $clog2(PERIOD_US);
  localparam int US_W      = $clog2(US_MAX + 1);
  localparam int SUB_W     = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_US - 1);
  localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]   TO_LIMIT  = US_W'(TIMEOUT_US);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] MAX_D     = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE_OK   = 3'd4,
    S_DONE_TO   = 3'd5,
    S_HOLDOFF   = 3'd6
  } state_t;

  state_t              r_state, w_next;
  logic                r_echo_s1, r_echo_s2, r_echo_d;
  logic                w_rise, w_fall, w_us_tick, w_cnt_run, w_trig_start;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic [US_W-1:0]     r_us_cnt;
  logic [SUB_W-1:0]    r_sub_cnt;
  logic [DIST_W-1:0]   r_cm_cnt;
  logic                r_trig, r_timeout, r_valid;
  logic [DIST_W-1:0]   r_dist;
  logic                w_commit;
  logic [DIST_W-1:0]   w_sample;

  assign w_rise       = r_echo_s2 & ~r_echo_d;
  assign w_fall       = ~r_echo_s2 & r_echo_d;
  assign w_us_tick    = (r_pre_cnt == PRE_LAST);
  assign w_cnt_run    = (r_state == S_TRIG) || (r_state == S_WAIT_RISE) || (r_state == S_MEASURE);
  assign w_trig_start = (w_next == S_TRIG) && (r_state != S_TRIG);
  assign w_commit     = (r_state == S_DONE_OK) || (r_state == S_DONE_TO);
  assign w_sample     = (r_state == S_DONE_OK) ? r_cm_cnt : MAX_D;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_us_tick) w_next = S_TRIG;
      S_TRIG:      if (w_us_tick && (r_us_cnt == TRIG_LAST)) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_rise)                     w_next = S_MEASURE;
        else if (r_us_cnt == TO_LIMIT)  w_next = S_DONE_TO;
      end
      // A fall coinciding with the limit still yields a valid distance.
      S_MEASURE: begin
        if (w_fall)                     w_next = S_DONE_OK;
        else if (r_us_cnt == TO_LIMIT)  w_next = S_DONE_TO;
      end
      S_DONE_OK:   w_next = S_HOLDOFF;
      S_DONE_TO:   w_next = S_HOLDOFF;
      S_HOLDOFF:   if (w_us_tick && (r_per_cnt == PER_LAST)) w_next = S_TRIG;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
      r_pre_cnt <= '0;
      r_per_cnt <= '0;
      r_us_cnt  <= '0;
      r_sub_cnt <= '0;
      r_cm_cnt  <= '0;
      r_trig    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_pre_cnt <= w_us_tick ? '0 : r_pre_cnt + 1'b1;
      r_trig    <= (w_next == S_TRIG);

      if (w_trig_start)
        r_per_cnt <= '0;
      else if (w_us_tick)
        r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + 1'b1;

      if (w_next != r_state)
        r_us_cnt <= '0;
      else if (w_us_tick && w_cnt_run)
        r_us_cnt <= r_us_cnt + 1'b1;

      // Ticks are counted through the fall-detect cycle so a width of N us counts exactly N.
      if ((r_state == S_WAIT_RISE) && w_rise) begin
        r_sub_cnt <= '0;
        r_cm_cnt  <= '0;
      end else if ((r_state == S_MEASURE) && w_us_tick) begin
        if (r_sub_cnt == SUB_LAST) begin
          r_sub_cnt <= '0;
          if (r_cm_cnt != MAX_D) r_cm_cnt <= r_cm_cnt + 1'b1;
        end else begin
          r_sub_cnt <= r_sub_cnt + 1'b1;
        end
      end

      if (w_commit) r_timeout <= (r_state == S_DONE_TO);
    end
  end

`ifdef ULTRASONIC_MEDIAN3_EN
  logic [DIST_W-1:0] r_h0, r_h1, r_h2;
  logic              r_stage_v;

  function automatic logic [DIST_W-1:0] f_median(input logic [DIST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b,
                                                  input logic [DIST_W-1:0] c);
    logic [DIST_W-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_h0      <= MAX_D;
      r_h1      <= MAX_D;
      r_h2      <= MAX_D;
      r_stage_v <= 1'b0;
      r_dist    <= MAX_D;
      r_valid   <= 1'b0;
    end else begin
      r_stage_v <= w_commit;
      r_valid   <= r_stage_v;
      if (w_commit) begin
        r_h0 <= w_sample;
        r_h1 <= r_h0;
        r_h2 <= r_h1;
      end
      if (r_stage_v) r_dist <= f_median(r_h0, r_h1, r_h2);
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dist  <= MAX_D;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) r_dist <= w_sample;
    end
  end
`endif

  assign trig        = r_trig;
  assign dist_cm     = r_dist;
  assign dist_valid  = r_valid;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule
